// File: rtl/fifo_rd_packer.sv
// Read-side drain for the async FIFO: packs RATIO show-ahead words into valid/ready beats.
// Define FIFO_RD_PACK_TIMEOUT_EN to auto-flush a partial beat after TIMEOUT idle cycles.
module fifo_rd_packer #(
    parameter int DSIZE   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy
);
    localparam int            CW   = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    typedef struct packed {
        logic [RATIO-1:0][DSIZE-1:0] data;
        logic [RATIO-1:0]            keep;
    } beat_t;

    logic [RATIO-1:0][DSIZE-1:0] acc;
    logic [CW-1:0]               cnt;
    logic [1:0]                  occ;
    logic                        flush_pend;
    beat_t                       buf_q [2];
    beat_t                       enq_beat;
    logic                        room, pop, full_enq, part_enq, enq, deq, tmo_hit;

    // Only rempty is combinational into rinc; m_ready is kept out of this path.
    assign room     = (occ != 2'd2);
    assign rinc     = !rst && !rempty && !flush_pend && ((cnt != LAST) || room);
    assign pop      = rinc;
    assign full_enq = pop && (cnt == LAST);
    assign part_enq = flush_pend && (cnt != '0) && room;
    assign enq      = full_enq || part_enq;
    assign m_valid  = (occ != 2'd0);
    assign deq      = m_valid && m_ready;
    assign m_data   = buf_q[0].data;
    assign m_keep   = buf_q[0].keep;
    assign busy     = (cnt != '0) || m_valid || flush_pend;

    // Lanes at or above cnt are always zero, so a partial beat needs no data masking.
    always_comb begin
        enq_beat.data = acc;
        enq_beat.keep = '1;
        if (full_enq)
            enq_beat.data[RATIO-1] = rdata;
        else
            for (int i = 0; i < RATIO; i++) enq_beat.keep[i] = (i < int'(cnt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (enq) begin
            acc <= '0;
            cnt <= '0;
        end else if (pop) begin
            acc[cnt] <= rdata;
            cnt      <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             flush_pend <= 1'b0;
        else if (flush_pend) flush_pend <= !((cnt == '0) || room);
        else                 flush_pend <= flush || tmo_hit;
    end

    // buf_q[0] is the head; buf_q[1] is only live when occ==2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            occ <= occ + {1'b0, enq} - {1'b0, deq};
            if (deq && occ == 2'd2)               buf_q[0] <= buf_q[1];
            else if (enq && (occ == 2'd0 || deq)) buf_q[0] <= enq_beat;
            if (enq && occ == 2'd1 && !deq)       buf_q[1] <= enq_beat;
        end
    end

`ifdef FIFO_RD_PACK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
    logic          idle_inc;

    assign idle_inc = (cnt != '0) && !pop && !flush_pend;
    assign tmo_hit  = idle_inc && (idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       idle_cnt <= '0;
        else if (!idle_inc || tmo_hit) idle_cnt <= '0;
        else                           idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed steps plus random traffic against a word-queue packing model.
module tb_fifo_rd_packer;
    localparam int DSIZE   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;
    localparam int W       = DSIZE * RATIO;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DSIZE-1:0] rdata;
    logic             rempty, rinc, flush, m_valid, m_ready, busy;
    logic [W-1:0]     m_data;
    logic [RATIO-1:0] m_keep;

    fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rdata(rdata), .rempty(rempty), .rinc(rinc), .flush(flush),
        .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DSIZE-1:0] src_q[$];   // words the FIFO still holds
    logic [DSIZE-1:0] pend_q[$];  // popped words not yet in a beat
    logic [W-1:0]     exp_d[$];
    logic [RATIO-1:0] exp_k[$];
    int n_checks = 0, n_pass = 0, n_fail = 0, n_pops = 0, n_beats = 0, idle_m = 0;
    bit hold_empty = 1'b0;
    logic             obs_rinc, obs_valid, obs_busy;
    logic [W-1:0]     obs_data;
    logic [RATIO-1:0] obs_keep;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        rempty = hold_empty || (src_q.size() == 0);
        rdata  = rempty ? DSIZE'($urandom) : src_q[0];
    endtask

    task automatic push(input logic [DSIZE-1:0] w);
        src_q.push_back(w);
        drive();
    endtask

    // Pending words become one beat: first word in lane 0, keep marks filled lanes.
    task automatic model_flush();
        logic [W-1:0]     d;
        logic [RATIO-1:0] k;
        idle_m = 0;
        if (pend_q.size() == 0) return;
        d = '0;
        k = '0;
        foreach (pend_q[i]) begin
            d[i*DSIZE +: DSIZE] = pend_q[i];
            k[i] = 1'b1;
        end
        exp_d.push_back(d);
        exp_k.push_back(k);
        pend_q.delete();
    endtask

    task automatic model_clear();
        pend_q.delete();
        exp_d.delete();
        exp_k.delete();
        idle_m = 0;
    endtask

    // One clock: observe at negedge, update the model after the posedge, re-drive inputs.
    task automatic cyc();
        logic pop;
        @(negedge clk);
        obs_rinc  = rinc;
        obs_valid = m_valid;
        obs_data  = m_data;
        obs_keep  = m_keep;
        obs_busy  = busy;
        pop       = rinc;
        if (m_valid && m_ready) begin
            n_beats++;
            check("beat_expected", exp_d.size() != 0, 1'b1);
            if (exp_d.size() != 0) begin
                check("beat_data", m_data, exp_d.pop_front());
                check("beat_keep", m_keep, exp_k.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (pop) begin
            n_pops++;
            pend_q.push_back(src_q.pop_front());
            if (pend_q.size() == RATIO) model_flush();
        end
`ifdef FIFO_RD_PACK_TIMEOUT_EN
        if (pop || pend_q.size() == 0) idle_m = 0;
        else if (++idle_m == TIMEOUT) model_flush();
`endif
        if (flush && !rst) model_flush();
        flush = 1'b0;
        drive();
    endtask

    task automatic drain(input string tag);
        m_ready    = 1'b1;
        hold_empty = 1'b0;
        drive();
        for (int i = 0; i < 2000; i++) begin
            if (i > 2 && src_q.size() == 0 && exp_d.size() == 0 && pend_q.size() == 0 && !obs_busy)
                break;
            if (src_q.size() == 0 && pend_q.size() != 0 && i % 4 == 0) flush = 1'b1;
            cyc();
        end
        check(tag, {src_q.size() == 0, exp_d.size() == 0, pend_q.size() == 0, obs_busy}, 4'b1110);
    endtask

    initial begin
        int base, base_b, waitc;
        flush   = 1'b0;
        m_ready = 1'b1;
        drive();

        // Reset with data waiting
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        cyc(); cyc();
        check("rst_rinc",  obs_rinc,  1'b0);
        check("rst_valid", obs_valid, 1'b0);
        check("rst_keep",  obs_keep,  4'h0);
        check("rst_data",  obs_data,  32'h0);
        check("rst_busy",  obs_busy,  1'b0);
        rst = 1'b0;
        cyc();
        check("rinc_after_rst", obs_rinc, 1'b1);

        // Full beat, one cycle after the 4th pop, for exactly one cycle
        cyc(); cyc(); cyc();
        cyc();
        check("full_valid", obs_valid, 1'b1);
        check("full_data",  obs_data,  32'h44332211);
        check("full_keep",  obs_keep,  4'hF);
        cyc();
        check("full_valid_once", obs_valid, 1'b0);

        // Backpressure: 2 beats + RATIO-1 words held
        m_ready = 1'b0;
        base = n_pops;
        for (int i = 0; i < 12; i++) push(DSIZE'(8'h60 + i));
        repeat (20) cyc();
        check("bp_pops",  n_pops - base, 11);
        check("bp_rinc",  obs_rinc, 1'b0);
        check("bp_valid", obs_valid, 1'b1);
        check("bp_data1", obs_data, 32'h63626160);
        m_ready = 1'b1;
        base_b  = n_beats;
        cyc();
        check("bp_rinc_held", obs_rinc, 1'b0);
        cyc();
        check("bp_rinc_resume", obs_rinc, 1'b1);
        check("bp_beats",       n_beats - base_b, 2);
        drain("bp_drain");

        // Flush of a 2-word partial, then a flush with nothing pending
        push(8'hAA); push(8'hBB);
        cyc(); cyc();
        flush = 1'b1;
        cyc();
        cyc();
        check("fl_valid_t1", obs_valid, 1'b0);
        cyc();
        check("fl_valid_t2", obs_valid, 1'b1);
        check("fl_data",     obs_data,  32'h0000BBAA);
        check("fl_keep",     obs_keep,  4'b0011);
        base_b = n_beats;
        flush  = 1'b1;
        repeat (10) cyc();
        check("fl_empty_nobeat", n_beats - base_b, 0);
        check("fl_empty_busy",   obs_busy, 1'b0);

        // Flush in the same cycle as a pop
        push(8'hAA); push(8'hBB);
        cyc(); cyc();
        push(8'hCC);
        flush = 1'b1;
        cyc();
        cyc(); cyc();
        check("flpop_valid", obs_valid, 1'b1);
        check("flpop_data",  obs_data,  32'h00CCBBAA);
        check("flpop_keep",  obs_keep,  4'b0111);
        drain("flpop_drain");

        // Single word then idle
        push(8'h5A);
        cyc();
`ifdef FIFO_RD_PACK_TIMEOUT_EN
        waitc = 0;
        for (int i = 0; i < 40 && !obs_valid; i++) begin
            cyc();
            waitc++;
        end
        check("tmo_latency", (waitc >= 17) && (waitc <= 19), 1'b1);
        check("tmo_data",    obs_data, 32'h0000005A);
        check("tmo_keep",    obs_keep, 4'b0001);
`else
        base_b = n_beats;
        repeat (100) cyc();
        check("notmo_nobeat", n_beats - base_b, 0);
        check("notmo_busy",   obs_busy, 1'b1);
`endif
        drain("tmo_drain");

        // Reset in the middle of a held beat and a partial accumulation
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(DSIZE'($urandom));
        repeat (8) cyc();
        check("mid_busy_before", obs_busy, 1'b1);
        rst = 1'b1;
        cyc();
        check("mid_rst_valid", obs_valid, 1'b0);
        check("mid_rst_busy",  obs_busy,  1'b0);
        model_clear();
        rst = 1'b0;
        drain("mid_rst_drain");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0) src_q.push_back(DSIZE'($urandom));
            hold_empty = ($urandom_range(0, 4) == 0);
            m_ready    = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            drive();
            cyc();
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
